// File: rtl/uart_mem_bridge.sv
// ==== uart_mem_bridge : host byte-stream (W/R/B) to RAM port decoder, rev 1.0 ====
`default_nettype none

module uart_mem_bridge #(
  parameter int ADDR_BYTES     = 4,
  parameter int DATA_BYTES     = 4,
  parameter int READ_LATENCY   = 2,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [7:0]              rx_data_in,
  input  logic                    rx_valid_in,
  output logic [7:0]              tx_data_out,
  output logic                    tx_valid_out,
  input  logic                    tx_ready_in,
  output logic [8*ADDR_BYTES-1:0] mem_addr_out,
  output logic [8*DATA_BYTES-1:0] mem_wdata_out,
  output logic                    mem_we_out,
  output logic                    mem_re_out,
  input  logic [8*DATA_BYTES-1:0] mem_rdata_in,
  output logic                    busy_out,
  output logic                    error_out
);

  localparam int AW = 8 * ADDR_BYTES;
  localparam int DW = 8 * DATA_BYTES;
  localparam int GW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [7:0]    CMD_W     = 8'h57;
  localparam logic [7:0]    CMD_R     = 8'h52;
  localparam logic [7:0]    CMD_B     = 8'h42;
  localparam logic [7:0]    ACK_BYTE  = 8'h4B;
  localparam logic [1:0]    ADDR_LAST = 2'(ADDR_BYTES - 1);
  localparam logic [1:0]    DATA_LAST = 2'(DATA_BYTES - 1);
  localparam logic [2:0]    RD_LAST   = 3'(READ_LATENCY);
  localparam logic [2:0]    TX_WORD   = 3'(DATA_BYTES);
  localparam logic [AW-1:0] ADDR_STEP = AW'(DATA_BYTES);
  localparam logic [GW-1:0] GAP_LAST  = GW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_COUNT = 3'd2,
    S_DATA  = 3'd3,
    S_MEMWR = 3'd4,
    S_MEMRD = 3'd5,
    S_TX    = 3'd6
  } state_t;

  state_t        state;
  logic [7:0]    cmd;
  logic [1:0]    byte_idx;
  logic [8:0]    words_left;
  logic [AW-1:0] addr_sh;
  logic [AW-1:0] addr_next;
  logic [DW-1:0] data_sh;
  logic [DW-1:0] data_next;
  logic [DW-1:0] tx_sh;
  logic [2:0]    tx_left;
  logic [2:0]    rd_cnt;
  logic [GW-1:0] gap;
  logic          gap_expired;
  logic          collecting;

  // Little-endian assembly: the incoming byte lands at the current byte index.
  always_comb begin
    addr_next = addr_sh;
    data_next = data_sh;
    for (int i = 0; i < ADDR_BYTES; i++) begin
      if (byte_idx == 2'(i)) addr_next[8*i +: 8] = rx_data_in;
    end
    for (int i = 0; i < DATA_BYTES; i++) begin
      if (byte_idx == 2'(i)) data_next[8*i +: 8] = rx_data_in;
    end
  end

  assign collecting  = (state == S_ADDR) || (state == S_COUNT) || (state == S_DATA);
  assign gap_expired = (TIMEOUT_CYCLES > 0) && (gap == GAP_LAST);
  assign busy_out    = (state != S_IDLE);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state         <= S_IDLE;
      cmd           <= '0;
      byte_idx      <= '0;
      words_left    <= '0;
      addr_sh       <= '0;
      data_sh       <= '0;
      tx_sh         <= '0;
      tx_left       <= '0;
      rd_cnt        <= '0;
      gap           <= '0;
      tx_data_out   <= '0;
      tx_valid_out  <= 1'b0;
      mem_addr_out  <= '0;
      mem_wdata_out <= '0;
      mem_we_out    <= 1'b0;
      mem_re_out    <= 1'b0;
      error_out     <= 1'b0;
    end else begin
      mem_we_out <= 1'b0;
      mem_re_out <= 1'b0;
      error_out  <= 1'b0;

      if (rx_valid_in || !collecting) gap <= '0;
      else                            gap <= gap + 1'b1;

      case (state)
        S_IDLE: begin
          if (rx_valid_in && (rx_data_in == CMD_W || rx_data_in == CMD_R ||
                              rx_data_in == CMD_B)) begin
            cmd      <= rx_data_in;
            byte_idx <= '0;
            state    <= S_ADDR;
          end
        end

        S_ADDR: begin
          if (rx_valid_in) begin
            addr_sh <= addr_next;
            if (byte_idx == ADDR_LAST) begin
              byte_idx     <= '0;
              mem_addr_out <= addr_next;
              case (cmd)
                CMD_W: begin
                  words_left <= 9'd1;
                  state      <= S_DATA;
                end
                CMD_B:   state <= S_COUNT;
                default: begin
                  mem_re_out <= 1'b1;
                  rd_cnt     <= '0;
                  state      <= S_MEMRD;
                end
              endcase
            end else begin
              byte_idx <= byte_idx + 1'b1;
            end
          end else if (gap_expired) begin
            error_out <= 1'b1;
            state     <= S_IDLE;
          end
        end

        S_COUNT: begin
          if (rx_valid_in) begin
            words_left <= (rx_data_in == 8'd0) ? 9'd256 : {1'b0, rx_data_in};
            byte_idx   <= '0;
            state      <= S_DATA;
          end else if (gap_expired) begin
            error_out <= 1'b1;
            state     <= S_IDLE;
          end
        end

        S_DATA: begin
          if (rx_valid_in) begin
            data_sh <= data_next;
            if (byte_idx == DATA_LAST) begin
              byte_idx      <= '0;
              mem_wdata_out <= data_next;
              mem_we_out    <= 1'b1;
              state         <= S_MEMWR;
            end else begin
              byte_idx <= byte_idx + 1'b1;
            end
          end else if (gap_expired) begin
            byte_idx  <= '0;
            error_out <= 1'b1;
            state     <= S_IDLE;
          end
        end

        S_MEMWR: begin
          mem_addr_out <= mem_addr_out + ADDR_STEP;
          words_left   <= words_left - 1'b1;
          if (words_left != 9'd1) begin
            // A byte arriving here belongs to the next burst word; keep it.
            state <= S_DATA;
            if (rx_valid_in) begin
              data_sh <= data_next;
              if (byte_idx == DATA_LAST) begin
                mem_wdata_out <= data_next;
                mem_we_out    <= 1'b1;
                state         <= S_MEMWR;
              end else begin
                byte_idx <= byte_idx + 1'b1;
              end
            end
          end else begin
            if (rx_valid_in) error_out <= 1'b1;
            tx_data_out  <= ACK_BYTE;
            tx_sh        <= '0;
            tx_left      <= 3'd1;
            tx_valid_out <= 1'b1;
            state        <= S_TX;
          end
        end

        S_MEMRD: begin
          if (rx_valid_in) error_out <= 1'b1;
          if (rd_cnt == RD_LAST) begin
            tx_data_out  <= mem_rdata_in[7:0];
            tx_sh        <= mem_rdata_in >> 8;
            tx_left      <= TX_WORD;
            tx_valid_out <= 1'b1;
            state        <= S_TX;
          end else begin
            rd_cnt <= rd_cnt + 1'b1;
          end
        end

        S_TX: begin
          if (rx_valid_in) error_out <= 1'b1;
          if (tx_ready_in) begin
            if (tx_left == 3'd1) begin
              tx_valid_out <= 1'b0;
              state        <= S_IDLE;
            end else begin
              tx_data_out <= tx_sh[7:0];
              tx_sh       <= tx_sh >> 8;
              tx_left     <= tx_left - 1'b1;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
